// File: rtl/axi_ic_bresp.sv
// AXI write-response return path: routes each slave BRESP beat to the master
// encoded in the upper BID bits through a per-master round-robin arbiter and a one-entry output stage.
module axi_ic_bresp #(
    parameter int MSTR_NUM  = 2,
    parameter int SLV_NUM   = 3,
    parameter int MSTR_BITS = 1,
    parameter int ID_BITS   = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [SLV_NUM*ID_BITS-1:0]             S_BID,
    input  logic [SLV_NUM*2-1:0]                   S_BRESP,
    input  logic [SLV_NUM-1:0]                     S_BVALID,
    output logic [SLV_NUM-1:0]                     S_BREADY,
    output logic [MSTR_NUM*(ID_BITS-MSTR_BITS)-1:0] M_BID,
    output logic [MSTR_NUM*2-1:0]                  M_BRESP,
    output logic [MSTR_NUM-1:0]                    M_BVALID,
    input  logic [MSTR_NUM-1:0]                    M_BREADY,
    output logic                                   decerr,
    output logic [7:0]                             decerr_cnt
);
    localparam int LOW_W = ID_BITS - MSTR_BITS;
    localparam int PTR_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
    localparam int MAP_N = 1 << MSTR_BITS;

    logic [LOW_W-1:0]     w_slv_id   [SLV_NUM];
    logic [1:0]           w_slv_resp [SLV_NUM];
    logic [MSTR_BITS-1:0] w_tgt      [SLV_NUM];
    logic [SLV_NUM-1:0]   w_legal;
    logic [SLV_NUM-1:0]   w_illegal;
    logic [MAP_N-1:0]     w_legal_map;

    logic [MSTR_NUM-1:0]             w_grant;
    logic [MSTR_NUM-1:0][PTR_W-1:0]  w_win;

    logic       r_decerr;
    logic [7:0] r_decerr_cnt;
    logic [8:0] w_cnt_sum;

    // Lookup of which encodable master indices actually exist.
    for (genvar gi = 0; gi < MAP_N; gi++) begin : g_map
        assign w_legal_map[gi] = (gi < MSTR_NUM);
    end

    for (genvar gi = 0; gi < SLV_NUM; gi++) begin : g_slv
        logic w_hit;

        assign w_slv_id[gi]   = S_BID[gi*ID_BITS +: LOW_W];
        assign w_tgt[gi]      = S_BID[gi*ID_BITS + LOW_W +: MSTR_BITS];
        assign w_slv_resp[gi] = S_BRESP[gi*2 +: 2];
        assign w_legal[gi]    = w_legal_map[w_tgt[gi]];
        assign w_illegal[gi]  = S_BVALID[gi] & ~w_legal[gi];

        always_comb begin
            w_hit = 1'b0;
            for (int m = 0; m < MSTR_NUM; m++) begin
                if (w_grant[m] && (w_win[m] == PTR_W'(gi)))
                    w_hit = 1'b1;
            end
        end

        // Illegal beats are sunk immediately so they never block the slave.
        assign S_BREADY[gi] = reset & (w_illegal[gi] | w_hit);
    end

    for (genvar gi = 0; gi < MSTR_NUM; gi++) begin : g_mst
        logic [SLV_NUM-1:0] w_req;
        logic [PTR_W-1:0]   w_sel;
        logic               w_load;
        logic [PTR_W-1:0]   r_rr_ptr;
        logic               r_bvalid;
        logic [LOW_W-1:0]   r_bid;
        logic [1:0]         r_bresp;

        for (genvar gj = 0; gj < SLV_NUM; gj++) begin : g_req
            assign w_req[gj] = S_BVALID[gj] & w_legal[gj] & (w_tgt[gj] == MSTR_BITS'(gi));
        end

        // Scan downwards so the lowest offset from the pointer wins last.
        always_comb begin
            w_sel = r_rr_ptr;
            for (int i = SLV_NUM - 1; i >= 0; i--) begin
                if (w_req[PTR_W'((int'(r_rr_ptr) + i) % SLV_NUM)])
                    w_sel = PTR_W'((int'(r_rr_ptr) + i) % SLV_NUM);
            end
        end

        assign w_load      = ~r_bvalid | M_BREADY[gi];
        assign w_grant[gi] = w_load & (|w_req);
        assign w_win[gi]   = w_sel;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_bvalid <= 1'b0;
                r_bid    <= '0;
                r_bresp  <= '0;
                r_rr_ptr <= '0;
            end else if (w_load) begin
                if (|w_req) begin
                    r_bvalid <= 1'b1;
                    r_bid    <= w_slv_id[w_sel];
                    r_bresp  <= w_slv_resp[w_sel];
                    r_rr_ptr <= PTR_W'((int'(w_sel) + 1) % SLV_NUM);
                end else begin
                    r_bvalid <= 1'b0;
                end
            end
        end

        assign M_BVALID[gi]               = r_bvalid;
        assign M_BID[gi*LOW_W +: LOW_W]   = r_bid;
        assign M_BRESP[gi*2 +: 2]         = r_bresp;
    end

    assign w_cnt_sum = {1'b0, r_decerr_cnt} + 9'($countones(w_illegal));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_decerr     <= 1'b0;
            r_decerr_cnt <= '0;
        end else begin
            r_decerr     <= |w_illegal;
            r_decerr_cnt <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
        end
    end

    assign decerr     = r_decerr;
    assign decerr_cnt = r_decerr_cnt;

endmodule

// File: tb/tb_axi_ic_bresp.sv
// Directed bench for axi_ic_bresp: default 2-master instance plus a 3-master
// instance for illegal master indices; delivered beats are checked against a per-master scoreboard.
module tb_axi_ic_bresp;
    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] s_bid;
    logic [5:0]  s_bresp;
    logic [2:0]  s_bvalid;
    logic [2:0]  s_bready;
    logic [5:0]  m_bid;
    logic [3:0]  m_bresp;
    logic [1:0]  m_bvalid;
    logic [1:0]  m_bready;
    logic        decerr;
    logic [7:0]  decerr_cnt;

    logic [11:0] s3_bid;
    logic [5:0]  s3_bresp;
    logic [2:0]  s3_bvalid;
    logic [2:0]  s3_bready;
    logic [5:0]  m3_bid;
    logic [5:0]  m3_bresp;
    logic [2:0]  m3_bvalid;
    logic [2:0]  m3_bready;
    logic        decerr3;
    logic [7:0]  decerr3_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [4:0] q0[$];
    logic [4:0] q1[$];

    always #5 clk = ~clk;

    axi_ic_bresp #(.MSTR_NUM(2), .SLV_NUM(3), .MSTR_BITS(1), .ID_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .S_BID(s_bid), .S_BRESP(s_bresp), .S_BVALID(s_bvalid), .S_BREADY(s_bready),
        .M_BID(m_bid), .M_BRESP(m_bresp), .M_BVALID(m_bvalid), .M_BREADY(m_bready),
        .decerr(decerr), .decerr_cnt(decerr_cnt)
    );

    axi_ic_bresp #(.MSTR_NUM(3), .SLV_NUM(3), .MSTR_BITS(2), .ID_BITS(4)) dut3 (
        .clk(clk), .reset(reset),
        .S_BID(s3_bid), .S_BRESP(s3_bresp), .S_BVALID(s3_bvalid), .S_BREADY(s3_bready),
        .M_BID(m3_bid), .M_BRESP(m3_bresp), .M_BVALID(m3_bvalid), .M_BREADY(m3_bready),
        .decerr(decerr3), .decerr_cnt(decerr3_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of slave traffic, check S_BREADY mid-cycle, and record
    // the beats expected to be accepted for delivery.
    task automatic step(input logic [2:0] v, input logic [11:0] bid, input logic [5:0] resp,
                        input logic [1:0] mrdy, input logic [2:0] exp_rdy, input string tag);
        logic [4:0] e;
        s_bvalid = v;
        s_bid    = bid;
        s_bresp  = resp;
        m_bready = mrdy;
        @(negedge clk);
        chk(tag, 32'(s_bready), 32'(exp_rdy));
        for (int s = 0; s < 3; s++) begin
            if (exp_rdy[s]) begin
                e = {bid[s*4 +: 3], resp[s*2 +: 2]};
                if (bid[s*4 + 3]) q1.push_back(e);
                else              q0.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (m_bvalid[0] && m_bready[0]) begin
                chk("m0_expected", 32'(q0.size() > 0), 32'd1);
                if (q0.size() > 0) chk("m0_beat", 32'({m_bid[2:0], m_bresp[1:0]}), 32'(q0.pop_front()));
            end
            if (m_bvalid[1] && m_bready[1]) begin
                chk("m1_expected", 32'(q1.size() > 0), 32'd1);
                if (q1.size() > 0) chk("m1_beat", 32'({m_bid[5:3], m_bresp[3:2]}), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        reset     = 1'b0;
        s_bvalid  = 3'b111;
        s_bid     = '0;
        s_bresp   = '0;
        m_bready  = 2'b11;
        s3_bvalid = '0;
        s3_bid    = '0;
        s3_bresp  = '0;
        m3_bready = 3'b111;

        // Reset state
        @(negedge clk);
        chk("rst_bvalid", 32'(m_bvalid), 32'd0);
        chk("rst_bid", 32'(m_bid), 32'd0);
        chk("rst_bresp", 32'(m_bresp), 32'd0);
        chk("rst_decerr", 32'(decerr), 32'd0);
        chk("rst_decerr_cnt", 32'(decerr_cnt), 32'd0);
        chk("rst_sready", 32'(s_bready), 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        s_bvalid = '0;

        // Single response to master 1
        step(3'b010, {4'b0000, 4'b1011, 4'b0000}, 6'b0, 2'b11, 3'b010, "single_sready");
        chk("single_bvalid", 32'(m_bvalid), 32'b10);
        chk("single_bid", 32'(m_bid[5:3]), 32'b011);
        chk("single_bresp", 32'(m_bresp[3:2]), 32'b00);
        step(3'b000, 12'h0, 6'b0, 2'b11, 3'b000, "single_idle");
        chk("single_clear", 32'(m_bvalid), 32'b00);

        // Contention: three slaves on master 0, strict rotation without bubbles
        for (int k = 0; k < 6; k++) begin
            step(3'b111, {4'b0100, 4'b0010, 4'b0001}, {2'b11, 2'b10, 2'b01}, 2'b11,
                 3'(1 << (k % 3)), "contend_grant");
            chk("contend_valid", 32'(m_bvalid[0]), 32'd1);
        end
        step(3'b000, 12'h0, 6'b0, 2'b11, 3'b000, "contend_idle");

        // Backpressure on master 0 while master 1 keeps flowing
        step(3'b001, {4'b0000, 4'b0000, 4'b0101}, 6'b000010, 2'b00, 3'b001, "bp_load");
        for (int k = 0; k < 5; k++) begin
            step(3'b110, {1'b1, 3'(k), 4'b0110, 4'b0000}, {2'(k), 2'b01, 2'b00}, 2'b10,
                 3'b100, "bp_sready");
            chk("bp_valid", 32'(m_bvalid[0]), 32'd1);
            chk("bp_bid", 32'(m_bid[2:0]), 32'b101);
            chk("bp_bresp", 32'(m_bresp[1:0]), 32'b10);
        end
        step(3'b010, {4'b0000, 4'b0110, 4'b0000}, 6'b000100, 2'b11, 3'b010, "bp_release");
        step(3'b000, 12'h0, 6'b0, 2'b11, 3'b000, "bp_idle");

        // Parallel masters
        step(3'b101, {4'b1010, 4'b0000, 4'b0011}, {2'b11, 2'b00, 2'b01}, 2'b11, 3'b101, "par_sready");
        chk("par_bvalid", 32'(m_bvalid), 32'b11);
        step(3'b000, 12'h0, 6'b0, 2'b11, 3'b000, "par_idle");

        // Reset mid-operation
        step(3'b010, {4'b0000, 4'b0110, 4'b0000}, 6'b0, 2'b11, 3'b010, "rst_load");
        chk("rst_pre_valid", 32'(m_bvalid[0]), 32'd1);
        s_bvalid = 3'b111;
        s_bid    = {4'b0100, 4'b0010, 4'b0001};
        #1;
        reset = 1'b0;
        #1;
        chk("rst_async_valid", 32'(m_bvalid), 32'd0);
        chk("rst_async_sready", 32'(s_bready), 32'd0);
        q0.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(3'b111, {4'b0100, 4'b0010, 4'b0001}, 6'b0, 2'b11, 3'b001, "rst_rr_first");
        step(3'b111, {4'b0100, 4'b0010, 4'b0001}, 6'b0, 2'b11, 3'b010, "rst_rr_second");
        step(3'b000, 12'h0, 6'b0, 2'b11, 3'b000, "rst_idle");
        step(3'b000, 12'h0, 6'b0, 2'b11, 3'b000, "rst_idle2");

        // Illegal master index on the 3-master instance
        s3_bid    = {4'b1100, 8'h00};
        s3_bvalid = 3'b100;
        @(negedge clk);
        chk("ill_sready", 32'(s3_bready), 32'b100);
        @(posedge clk);
        #1;
        s3_bvalid = 3'b000;
        chk("ill_decerr", 32'(decerr3), 32'd1);
        chk("ill_cnt1", 32'(decerr3_cnt), 32'd1);
        chk("ill_no_bvalid", 32'(m3_bvalid), 32'd0);
        @(posedge clk);
        #1;
        chk("ill_pulse_once", 32'(decerr3), 32'd0);
        chk("ill_cnt_hold", 32'(decerr3_cnt), 32'd1);
        s3_bvalid = 3'b100;
        repeat (300) @(posedge clk);
        #1;
        s3_bvalid = 3'b000;
        @(posedge clk);
        #1;
        chk("ill_cnt_sat", 32'(decerr3_cnt), 32'd255);
        chk("ill_no_bvalid_end", 32'(m3_bvalid), 32'd0);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
